uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Transmit half of the UART controller: accepts bytes from the host bus into an internal FWFT FIFO and serialises them onto `tx_o` as start / 5-8 data (LSB first) / optional parity / 1-2 stop bits, one bit per 16 ticks of the shared oversampled baud strobe. Frame format and encodings match the receive path exactly. It also generates the SYN-based configuration-request sequence that the far-end receiver detects.

## Interface
- `FIFO_DEPTH`, 64, TX FIFO depth in words; power of two, at least 2.
- `COUNT_1MS`, 50000, number of `clk_i` cycles in 1 ms (50 MHz system clock).
- `SYN_NUMBER`, 3, number of SYN characters (0x16) in a configuration request.
- `clk_i  in  1  system clock`
- `rst_n_i  in  1  asynchronous, active-low reset`
- `enable_i  in  1  allows a new frame or sequence to start; ignored mid-frame`
- `ov_baud_rt_i  in  1  one-cycle strobe at 16x baud rate`
- `tx_fifo_write_i  in  1  push `tx_data_i` into the FIFO`
- `tx_data_i  in  8  data byte; only the low data_width bits are sent`
- `data_width_i  in  2  00=5, 01=6, 10=7, 11=8 bits`
- `stop_bits_number_i  in  2  01=two stop bits; any other value=one`
- `parity_mode_i  in  2  00=even, 01=odd, 1x=none`
- `config_req_mst_i  in  1  one-cycle request to send a configuration request`
- `tx_o  out  1  serial line; idle high`
- `tx_fifo_full_o  out  1  FIFO full`
- `tx_fifo_empty_o  out  1  FIFO empty`
- `tx_done_o  out  1  one-cycle pulse at the end of each frame`
- `tx_idle_o  out  1  high while in IDLE`
- `config_req_done_o  out  1  one-cycle pulse when the configuration-request sequence ends`

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP, CFG_SYN, CFG_HOLD.
- **Bit timing:** 4-bit tick counter; a bit ends on the `ov_baud_rt_i` tick where the counter equals 15. The counter then clears.
- **IDLE**
  - `tx_o`=1.
  - If `enable_i` is high and a configuration request is pending, go to CFG_SYN.
  - Otherwise, if `enable_i` is high and the FIFO is not empty:
    - pop the FIFO,
    - load the shift register,
    - latch `data_width_i`, `parity_mode_i` and `stop_bits_number_i` for the whole frame,
    - go to START.
- **START:** `tx_o`=0 for 16 ticks, then go to DATA.
- **DATA:** `tx_o` = shift[0]. Shift right on each bit end. After width bits, go to PARITY if parity is enabled, else go to STOP.
- **PARITY:** `tx_o` = XOR of the data bits for even parity, or its inverse for odd parity.
- **STOP:** `tx_o`=1 for 16 or 32 ticks. On completion, pulse `tx_done_o` and return to IDLE.
- **FIFO:** a write while full is dropped with no effect on contents. A simultaneous write and pop on a non-empty FIFO leaves the occupancy unchanged.
- **Disable and config changes:** deasserting `enable_i` or changing a config input mid-frame does not alter the frame in flight.
- **Configuration request:** a `config_req_mst_i` pulse sets a pending flag, including when it arrives mid-frame. The flag is cleared on entry to CFG_SYN.
  - **CFG_SYN:** send `SYN_NUMBER` frames of 0x16 using the latched format. FIFO data is never popped during this state. The far end detects SYN only in 8-bit mode.
  - **CFG_HOLD:** hold `tx_o`=0 for 2*`COUNT_1MS` `clk_i` cycles. Then pulse `config_req_done_o` and return to IDLE with `tx_o`=1.
  - **Priority:** a pending request wins over FIFO data in IDLE.

## Timing
- **Reset values:**
  - `tx_o`=1, `tx_idle_o`=1, `tx_fifo_empty_o`=1.
  - `tx_fifo_full_o`, `tx_done_o` and `config_req_done_o` are 0.
  - FIFO pointers are cleared, the pending flag is cleared, and the FSM is in IDLE.
- **Reset mid-frame:** `tx_o` returns to 1 immediately (asynchronous) and the in-flight frame is lost.
- **Registered outputs:** `tx_o` is driven from a register updated with the state.
- **Start latency into an empty FIFO:** write in cycle N, `tx_fifo_empty_o` falls in N+1, and `tx_o` falls in N+2.
- **Frame length:** 16 × (1 + width + parity + stop) ticks.
- **Back-to-back frames:** exactly one `clk_i` cycle of IDLE between the last stop-bit tick and the next START.
- **Flags:** `tx_fifo_full_o` and `tx_fifo_empty_o` are registered and update the cycle after the push or pop.

## Configuration
- **Macro `UART_TX_CFG_REQ_EN`.**
- **Defined:** the pending flag, CFG_SYN, CFG_HOLD and the hold counter are built, behaving as described above.
- **Undefined:**
  - `config_req_mst_i` is ignored and `config_req_done_o` is tied to 0.
  - No hold counter is built; the FSM has only IDLE, START, DATA, PARITY and STOP.

## Test plan
- **Basic frame:** 8-bit, no parity, 1 stop; write 0xA5 -> `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; a single `tx_done_o` pulse.
- **Parity and 2 stop bits:** 7-bit even parity, 2 stop bits; write 0x53 -> data 1100101, parity 0, then 32 ticks high. Odd parity gives parity 1.
- **5-bit truncation:** 5-bit; write 0xFF -> 5 ones sent and the upper bits never appear; frame length 16×7 ticks.
- **FIFO full and back-to-back:** write `FIFO_DEPTH`+1 words while disabled -> `tx_fifo_full_o`=1 and the extra word dropped. Enable -> `FIFO_DEPTH` frames with a one-cycle IDLE gap, then `tx_fifo_empty_o`=1.
- **Mid-frame changes and reset:** change `data_width_i` mid-frame -> frame unaffected. Assert `rst_n_i` during DATA -> `tx_o`=1 at once, all outputs at reset values.
- **Configuration request (macro on):** pulse `config_req_mst_i` during a frame -> the frame completes, then three 0x16 frames, `tx_o` low for 100000 cycles, one `config_req_done_o` pulse; queued FIFO data is sent afterwards.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit path: FWFT byte FIFO feeding a start/data/parity/stop serialiser.
// Define UART_TX_CFG_REQ_EN to build the SYN-based configuration-request sequencer.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 64,
  parameter int COUNT_1MS  = 50000,
  parameter int SYN_NUMBER = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       ov_baud_rt_i,
  input  logic       tx_fifo_write_i,
  input  logic [7:0] tx_data_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  input  logic [1:0] parity_mode_i,
  input  logic       config_req_mst_i,
  output logic       tx_o,
  output logic       tx_fifo_full_o,
  output logic       tx_fifo_empty_o,
  output logic       tx_done_o,
  output logic       tx_idle_o,
  output logic       config_req_done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
`ifdef UART_TX_CFG_REQ_EN
  localparam logic [2:0] S_CFG_SYN  = 3'd5;
  localparam logic [2:0] S_CFG_HOLD = 3'd6;
  localparam int HOLD_CYC = 2 * COUNT_1MS;
  localparam int HW       = $clog2(HOLD_CYC);
  localparam int SW       = $clog2(SYN_NUMBER + 1) + 1;
`endif

  // ---------------- FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic        full_q, empty_q;
  logic        push, pop, cfg_go;
  logic [7:0]  rd_data;

  assign push    = tx_fifo_write_i && !full_q;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + (AW+1)'(1);
    else if (pop && !push) count_n = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= tx_data_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_n;
      full_q  <= (count_n == (AW+1)'(FIFO_DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  // ---------------- serialiser ----------------
  logic [2:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [1:0] width_q, par_q, stop_q;
  logic       par_bit, stop2, tx_q, done_q, cfg_done_q;
  logic       bit_end;
  logic [2:0] last_bit;

  assign bit_end  = ov_baud_rt_i && (tick_cnt == 4'hF);
  assign last_bit = 3'd4 + {1'b0, width_q};

  // Parity covers only the bits actually sent for the selected width.
  function automatic logic calc_par(input logic [7:0] d, input logic [1:0] w,
                                    input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - w);
    return (^(d & mask)) ^ odd;
  endfunction

`ifdef UART_TX_CFG_REQ_EN
  logic          cfg_pend, cfg_act;
  logic [SW-1:0] syn_cnt;
  logic [HW-1:0] hold_cnt;
  assign cfg_go = (state == S_IDLE) && enable_i && cfg_pend;
`else
  logic unused_cfg;
  assign unused_cfg = config_req_mst_i;
  assign cfg_go     = 1'b0;
`endif

  assign pop = (state == S_IDLE) && enable_i && !empty_q && !cfg_go;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      width_q    <= '0;
      par_q      <= '0;
      stop_q     <= '0;
      par_bit    <= 1'b0;
      stop2      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      cfg_done_q <= 1'b0;
`ifdef UART_TX_CFG_REQ_EN
      cfg_pend   <= 1'b0;
      cfg_act    <= 1'b0;
      syn_cnt    <= '0;
      hold_cnt   <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      if (state != S_IDLE && ov_baud_rt_i) tick_cnt <= tick_cnt + 4'd1;
`ifdef UART_TX_CFG_REQ_EN
      cfg_pend <= config_req_mst_i || (cfg_pend && !cfg_go);
`endif
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          // Format is frozen here so mid-frame config changes cannot disturb the frame.
          if (cfg_go || pop) begin
            width_q <= data_width_i;
            par_q   <= parity_mode_i;
            stop_q  <= stop_bits_number_i;
          end
          if (pop) begin
            shift    <= rd_data;
            par_bit  <= calc_par(rd_data, data_width_i, parity_mode_i[0]);
            tick_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
`ifdef UART_TX_CFG_REQ_EN
          if (cfg_go) begin
            syn_cnt <= '0;
            cfg_act <= 1'b1;
            state   <= S_CFG_SYN;
          end
`endif
        end
        S_START:
          if (bit_end) begin
            bit_cnt <= '0;
            tx_q    <= shift[0];
            state   <= S_DATA;
          end
        S_DATA:
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == last_bit) begin
              if (!par_q[1]) begin
                tx_q  <= par_bit;
                state <= S_PARITY;
              end else begin
                tx_q  <= 1'b1;
                stop2 <= 1'b0;
                state <= S_STOP;
              end
            end else begin
              tx_q <= shift[1];
            end
          end
        S_PARITY:
          if (bit_end) begin
            tx_q  <= 1'b1;
            stop2 <= 1'b0;
            state <= S_STOP;
          end
        S_STOP:
          if (bit_end) begin
            if (stop_q == 2'b01 && !stop2) begin
              stop2 <= 1'b1;
            end else begin
              done_q <= 1'b1;
              tx_q   <= 1'b1;
`ifdef UART_TX_CFG_REQ_EN
              state  <= cfg_act ? S_CFG_SYN : S_IDLE;
`else
              state  <= S_IDLE;
`endif
            end
          end
`ifdef UART_TX_CFG_REQ_EN
        S_CFG_SYN: begin
          tx_q <= 1'b1;
          if (syn_cnt == SW'(SYN_NUMBER)) begin
            cfg_act  <= 1'b0;
            hold_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= S_CFG_HOLD;
          end else begin
            syn_cnt  <= syn_cnt + SW'(1);
            shift    <= 8'h16;
            par_bit  <= calc_par(8'h16, width_q, par_q[0]);
            tick_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
        end
        S_CFG_HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            tx_q       <= 1'b1;
            cfg_done_q <= 1'b1;
            state      <= S_IDLE;
          end
        end
`endif
        default: begin
          tx_q  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_o              = tx_q;
  assign tx_fifo_full_o    = full_q;
  assign tx_fifo_empty_o   = empty_q;
  assign tx_done_o         = done_q;
  assign tx_idle_o         = (state == S_IDLE);
  assign config_req_done_o = cfg_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line monitor decodes tx_o tick by tick against a
// queue of expected frames pushed when bytes are written.
module tb_uart_transmitter;
  localparam int DEPTH = 4;
  localparam int C1MS  = 20;

  logic clk = 0, rst_n = 0, enable = 0, baud = 0, wr = 0, cfg_req = 0;
  logic [7:0] data = 0;
  logic [1:0] dw = 2'b11, sb = 2'b00, pm = 2'b10;
  logic tx, full, empty, done, idle, cfg_done;

  uart_transmitter #(.FIFO_DEPTH(DEPTH), .COUNT_1MS(C1MS), .SYN_NUMBER(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .ov_baud_rt_i(baud),
    .tx_fifo_write_i(wr), .tx_data_i(data), .data_width_i(dw),
    .stop_bits_number_i(sb), .parity_mode_i(pm), .config_req_mst_i(cfg_req),
    .tx_o(tx), .tx_fifo_full_o(full), .tx_fifo_empty_o(empty), .tx_done_o(done),
    .tx_idle_o(idle), .config_req_done_o(cfg_done));

  always #5 clk = ~clk;

  // 16x strobe high every other cycle
  initial forever begin
    @(posedge clk);
    #1 baud = ~baud;
  end

  typedef struct { logic [11:0] bits; int n; } frame_t;
  frame_t exp_q[$];
  frame_t cur;
  int checks = 0, passes = 0;
  int frames_seen = 0, done_cnt = 0, cfgd_cnt = 0;
  int k = 0, bad_k = 0;
  logic busy = 0, bad = 0, bad_v = 0, done_due = 0, unexp = 0;
  logic mon_abort = 0, allow_low = 0;

  function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] w,
                                        input logic [1:0] p, input logic [1:0] s);
    frame_t f;
    logic par;
    f.bits = '1;
    f.n = 1;
    f.bits[0] = 1'b0;
    par = 1'b0;
    for (int i = 0; i < 5 + int'(w); i++) begin
      f.bits[f.n] = d[i];
      par ^= d[i];
      f.n++;
    end
    if (!p[1]) begin
      f.bits[f.n] = par ^ p[0];
      f.n++;
    end
    f.n += (s == 2'b01) ? 2 : 1;
    return f;
  endfunction

  // Line monitor: each frame bit must hold for 16 strobes; tx_done_o must follow the last one.
  always @(negedge clk) begin
    if (mon_abort || !rst_n) begin
      busy = 0;
      done_due = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (cfg_done === 1'b1) cfgd_cnt++;
      if (done_due) begin
        checks++;
        if (done !== 1'b1) $display("FAIL done_timing: tx_done_o=%b required 1 after frame %0d", done, frames_seen);
        else passes++;
        done_due = 0;
      end else if (done === 1'b1) begin
        checks++;
        $display("FAIL spurious_done: tx_done_o=1 required 0");
      end
      if (baud) begin
        if (!busy && tx === 1'b0) begin
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            busy = 1; k = 0; bad = 0;
          end else if (!allow_low && !unexp) begin
            checks++;
            unexp = 1;
            $display("FAIL unexpected_start: tx_o=0 required 1 (no frame queued)");
          end
        end
        if (tx === 1'b1) unexp = 0;
        if (busy) begin
          if (tx !== cur.bits[k/16]) begin
            if (!bad) begin bad_k = k; bad_v = tx; end
            bad = 1;
          end
          k++;
          if (k == 16 * cur.n) begin
            checks++;
            if (bad) $display("FAIL frame_%0d: bit %0d tx_o=%b required %b", frames_seen, bad_k/16, bad_v, cur.bits[bad_k/16]);
            else passes++;
            frames_seen++;
            busy = 0;
            done_due = 1;
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] d, input logic expect_it);
    @(negedge clk);
    data = d; wr = 1;
    if (expect_it) exp_q.push_back(make_frame(d, dw, pm, sb));
    @(negedge clk);
    wr = 0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin @(negedge clk); n++; end
    if (frames_seen < target) begin
      checks++;
      $display("FAIL %s_timeout: frames_seen=%0d required %0d", name, frames_seen, target);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (idle !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (idle !== 1'b0) begin
      checks++;
      $display("FAIL %s_start_timeout: tx_idle_o=%b required 0", name, idle);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 6;
    if (tx !== 1'b1) $display("FAIL rst_tx: tx_o=%b required 1", tx); else passes++;
    if (idle !== 1'b1) $display("FAIL rst_idle: tx_idle_o=%b required 1", idle); else passes++;
    if (empty !== 1'b1) $display("FAIL rst_empty: empty=%b required 1", empty); else passes++;
    if (full !== 1'b0) $display("FAIL rst_full: full=%b required 0", full); else passes++;
    if (done !== 1'b0) $display("FAIL rst_done: tx_done_o=%b required 0", done); else passes++;
    if (cfg_done !== 1'b0) $display("FAIL rst_cfg_done: config_req_done_o=%b required 0", cfg_done); else passes++;
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int base = frames_seen, d0 = done_cnt;
    dw = 2'b11; pm = 2'b10; sb = 2'b00; enable = 1;
    @(negedge clk);
    data = 8'hA5; wr = 1;
    exp_q.push_back(make_frame(8'hA5, dw, pm, sb));
    @(negedge clk);
    wr = 0;
    checks += 3;
    if (empty !== 1'b0) $display("FAIL lat_empty: empty=%b required 0", empty); else passes++;
    if (tx !== 1'b1) $display("FAIL lat_tx_hi: tx_o=%b required 1", tx); else passes++;
    @(negedge clk);
    if (tx !== 1'b0) $display("FAIL lat_tx_lo: tx_o=%b required 0", tx); else passes++;
    wait_frames(base + 1, 1000, "basic");
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: pulses=%0d required 1", done_cnt - d0); else passes++;
  endtask

  task automatic test_parity;
    int base = frames_seen;
    dw = 2'b10; sb = 2'b01; pm = 2'b00;
    write_byte(8'h53, 1);
    wait_frames(base + 1, 1000, "even");
    pm = 2'b01;
    write_byte(8'h53, 1);
    wait_frames(base + 2, 1000, "odd");
  endtask

  task automatic test_trunc;
    int base = frames_seen;
    dw = 2'b00; sb = 2'b00; pm = 2'b10;
    write_byte(8'hFF, 1);
    wait_frames(base + 1, 1000, "trunc");
  endtask

  task automatic test_back_to_back;
    int n;
    dw = 2'b11; sb = 2'b00; pm = 2'b10; enable = 0;
    for (int i = 0; i <= DEPTH; i++) write_byte(8'($urandom_range(0, 255)), i < DEPTH);
    @(negedge clk);
    checks += 2;
    if (full !== 1'b1) $display("FAIL fifo_full: full=%b required 1", full); else passes++;
    if (empty !== 1'b0) $display("FAIL fifo_not_empty: empty=%b required 0", empty); else passes++;
    enable = 1;
    for (int f = 0; f < DEPTH; f++) begin
      n = 0;
      while (done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (done !== 1'b1) $display("FAIL b2b_done_%0d: tx_done_o=%b required 1", f, done);
      else if (idle !== 1'b1) $display("FAIL b2b_idle_%0d: tx_idle_o=%b required 1", f, idle);
      else passes++;
      @(negedge clk);
      if (f < DEPTH - 1) begin
        checks++;
        if (tx !== 1'b0) $display("FAIL b2b_gap_%0d: tx_o=%b required 0", f, tx); else passes++;
      end
    end
    repeat (400) @(negedge clk);
    checks += 3;
    if (empty !== 1'b1) $display("FAIL b2b_empty: empty=%b required 1", empty); else passes++;
    if (full !== 1'b0) $display("FAIL b2b_full: full=%b required 0", full); else passes++;
    if (idle !== 1'b1) $display("FAIL b2b_dropped: tx_idle_o=%b required 1", idle); else passes++;
  endtask

  task automatic test_midframe;
    int base = frames_seen;
    dw = 2'b11; sb = 2'b00; pm = 2'b10; enable = 1;
    write_byte(8'h3C, 1);
    wait_busy("mid");
    repeat (60) @(negedge clk);
    dw = 2'b00; pm = 2'b01; sb = 2'b01; enable = 0;
    wait_frames(base + 1, 1000, "mid");
    dw = 2'b11; pm = 2'b10; sb = 2'b00; enable = 1;
  endtask

  task automatic test_reset_mid;
    dw = 2'b11; sb = 2'b00; pm = 2'b10; enable = 1;
    write_byte(8'h00, 1);
    wait_busy("rstmid");
    repeat (50) @(negedge clk);
    checks++;
    if (tx !== 1'b0) $display("FAIL pre_rst_tx: tx_o=%b required 0", tx); else passes++;
    mon_abort = 1;
    #2 rst_n = 0;
    #1;
    checks += 5;
    if (tx !== 1'b1) $display("FAIL rstmid_tx: tx_o=%b required 1", tx); else passes++;
    if (idle !== 1'b1) $display("FAIL rstmid_idle: tx_idle_o=%b required 1", idle); else passes++;
    if (empty !== 1'b1) $display("FAIL rstmid_empty: empty=%b required 1", empty); else passes++;
    if (full !== 1'b0) $display("FAIL rstmid_full: full=%b required 0", full); else passes++;
    if (done !== 1'b0) $display("FAIL rstmid_done: tx_done_o=%b required 0", done); else passes++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    mon_abort = 0;
    repeat (4) @(negedge clk);
  endtask

`ifdef UART_TX_CFG_REQ_EN
  task automatic test_cfg_req;
    int base = frames_seen, c0 = cfgd_cnt, n = 0, lowc = 0;
    dw = 2'b11; sb = 2'b00; pm = 2'b10; enable = 1;
    write_byte(8'h11, 1);
    wait_busy("cfg");
    @(negedge clk);
    cfg_req = 1; data = 8'h22; wr = 1;
    for (int i = 0; i < 3; i++) exp_q.push_back(make_frame(8'h16, dw, pm, sb));
    @(negedge clk);
    cfg_req = 0; wr = 0; allow_low = 1;
    wait_frames(base + 4, 4000, "cfg_syn");
    while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (tx === 1'b0 && lowc < 1000) begin lowc++; @(negedge clk); end
    checks += 2;
    if (lowc !== 2 * C1MS) $display("FAIL cfg_hold_len: low cycles=%0d required %0d", lowc, 2 * C1MS); else passes++;
    if (cfg_done !== 1'b1) $display("FAIL cfg_done_pulse: config_req_done_o=%b required 1", cfg_done); else passes++;
    allow_low = 0;
    exp_q.push_back(make_frame(8'h22, dw, pm, sb));
    wait_frames(base + 5, 1000, "cfg_fifo");
    checks++;
    if (cfgd_cnt - c0 !== 1) $display("FAIL cfg_done_count: pulses=%0d required 1", cfgd_cnt - c0); else passes++;
  endtask
`else
  task automatic test_cfg_ignored;
    enable = 1;
    @(negedge clk);
    cfg_req = 1;
    @(negedge clk);
    cfg_req = 0;
    repeat (200) @(negedge clk);
    checks += 3;
    if (idle !== 1'b1) $display("FAIL cfg_ign_idle: tx_idle_o=%b required 1", idle); else passes++;
    if (tx !== 1'b1) $display("FAIL cfg_ign_tx: tx_o=%b required 1", tx); else passes++;
    if (cfgd_cnt !== 0) $display("FAIL cfg_ign_done: pulses=%0d required 0", cfgd_cnt); else passes++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_trunc;
    test_back_to_back;
    test_midframe;
    test_reset_mid;
`ifdef UART_TX_CFG_REQ_EN
    test_cfg_req;
`else
    test_cfg_ignored;
`endif
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
